// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencer for a multi-cycle RV32I datapath
// that shares one ALU and one unified memory port.
// Inputs : clk, rst (sync, active high), opcode, funct3, funct7_5,
//          zero (ALU result == 0), mem_ready (memory access completes)
// Outputs: pc_wr_en, ir_wr_en, adr_src, mem_rd_en, mem_wr_en, reg_wr_en,
//          imm_src, alu_src_a, alu_src_b, alu_control, result_src,
//          illegal_instr, instr_done, state_o (debug view of the state)
module multicycle_controller #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         opcode,
   input  logic [2:0]         funct3,
   input  logic               funct7_5,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_wr_en,
   output logic               ir_wr_en,
   output logic               adr_src,
   output logic               mem_rd_en,
   output logic               mem_wr_en,
   output logic               reg_wr_en,
   output logic [2:0]         imm_src,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [3:0]         alu_control,
   output logic [1:0]         result_src,
   output logic               illegal_instr,
   output logic               instr_done,
   output logic [STATE_W-1:0] state_o
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADR  = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      EXEC_R   = 4'd6,
      EXEC_I   = 4'd7,
      ALU_WB   = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      JALR_ADR = 4'd11,
      JALR_PC  = 4'd12,
      LUI      = 4'd13
   } state_t;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   state_t state;
   state_t next;
   logic   taken;

   // funct7_5 selects SUB only for register ops; for immediates it is
   // part of the immediate except on the shift-right encoding.
   function automatic logic [3:0] alu_op(input logic [2:0] f3,
                                         input logic       f7,
                                         input logic       is_r);
      logic [3:0] op;
      case (f3)
         3'b000:  op = (is_r && f7) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = f7 ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= FETCH;
      else     state <= next;
   end

   always_comb begin
      case (opcode)
         OP_STORE:         imm_src = 3'b001;
         OP_BR:            imm_src = 3'b010;
         OP_LUI, OP_AUIPC: imm_src = 3'b011;
         OP_JAL:           imm_src = 3'b100;
         default:          imm_src = 3'b000;
      endcase
   end

   // Branch compare: SUB for equality, SLT/SLTU result in zero flag.
   always_comb begin
      case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = !zero;
         3'b100:  taken = !zero;
         3'b101:  taken = zero;
         3'b110:  taken = !zero;
         3'b111:  taken = zero;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      next          = state;
      pc_wr_en      = 1'b0;
      ir_wr_en      = 1'b0;
      adr_src       = 1'b0;
      mem_rd_en     = 1'b0;
      mem_wr_en     = 1'b0;
      reg_wr_en     = 1'b0;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_control   = ALU_ADD;
      result_src    = 2'b00;
      illegal_instr = 1'b0;
      instr_done    = 1'b0;

      unique case (state)
         FETCH: begin
            mem_rd_en  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            if (mem_ready) begin
               ir_wr_en = 1'b1;
               pc_wr_en = 1'b1;
               next     = DECODE;
            end
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (opcode)
               OP_LOAD, OP_STORE: next = MEM_ADR;
               OP_R:              next = EXEC_R;
               OP_I:              next = EXEC_I;
               OP_BR:             next = BRANCH;
               OP_JAL:            next = JAL;
               OP_JALR:           next = JALR_ADR;
               OP_LUI:            next = LUI;
               OP_AUIPC:          next = ALU_WB;
               default: begin
                  illegal_instr = 1'b1;
                  instr_done    = 1'b1;
                  next          = FETCH;
               end
            endcase
         end
         MEM_ADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            next      = opcode[5] ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            adr_src   = 1'b1;
            mem_rd_en = 1'b1;
            if (mem_ready) next = MEM_WB;
         end
         MEM_WB: begin
            result_src = 2'b01;
            reg_wr_en  = 1'b1;
            instr_done = 1'b1;
            next       = FETCH;
         end
         MEM_WR: begin
            adr_src   = 1'b1;
            mem_wr_en = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               next       = FETCH;
            end
         end
         EXEC_R: begin
            alu_src_a   = 2'b10;
            alu_control = alu_op(funct3, funct7_5, 1'b1);
            next        = ALU_WB;
         end
         EXEC_I: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b01;
            alu_control = alu_op(funct3, funct7_5, 1'b0);
            next        = ALU_WB;
         end
         ALU_WB: begin
            reg_wr_en  = 1'b1;
            instr_done = 1'b1;
            next       = FETCH;
         end
         BRANCH: begin
            alu_src_a = 2'b10;
            case (funct3)
               3'b100, 3'b101: alu_control = ALU_SLT;
               3'b110, 3'b111: alu_control = ALU_SLTU;
               default:        alu_control = ALU_SUB;
            endcase
            pc_wr_en   = taken;
            instr_done = 1'b1;
            next       = FETCH;
         end
         JAL, JALR_PC: begin
            // PC takes the target from alu_out while the ALU
            // forms old_pc+4 as the link value.
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_wr_en  = 1'b1;
            next      = ALU_WB;
         end
         JALR_ADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            next      = JALR_PC;
         end
         LUI: begin
            result_src = 2'b11;
            reg_wr_en  = 1'b1;
            instr_done = 1'b1;
            next       = FETCH;
         end
         default: next = FETCH;
      endcase

      // Reset must suppress any write or pulse in the current cycle.
      if (rst) begin
         pc_wr_en      = 1'b0;
         ir_wr_en      = 1'b0;
         mem_rd_en     = 1'b0;
         mem_wr_en     = 1'b0;
         reg_wr_en     = 1'b0;
         illegal_instr = 1'b0;
         instr_done    = 1'b0;
      end
   end

   assign state_o = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench for multicycle_controller.
// Expected per-cycle outputs are queued as stimulus is driven.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = 7'b0110011;
   logic [2:0] funct3 = 3'b000;
   logic       funct7_5 = 1'b0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       pc_wr_en, ir_wr_en, adr_src, mem_rd_en, mem_wr_en;
   logic       reg_wr_en, illegal_instr, instr_done;
   logic [2:0] imm_src;
   logic [1:0] alu_src_a, alu_src_b, result_src;
   logic [3:0] alu_control;
   logic [3:0] state_o;

   typedef struct {
      int st;
      int en;
      int alu;
      int rs;
      int sel;
      int imm;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [6:0] n_op  = 7'b0110011;
   logic [2:0] n_f3  = 3'b000;
   logic       n_f7  = 1'b0;
   logic       n_rst = 1'b1;

   multicycle_controller #(.STATE_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
      .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready),
      .pc_wr_en(pc_wr_en), .ir_wr_en(ir_wr_en), .adr_src(adr_src),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
      .reg_wr_en(reg_wr_en), .imm_src(imm_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_control(alu_control), .result_src(result_src),
      .illegal_instr(illegal_instr), .instr_done(instr_done),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // en = {pc, ir, mem_rd, mem_wr, reg, illegal, done}
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("state", int'(state_o), e.st);
         check("enables", int'({pc_wr_en, ir_wr_en, mem_rd_en,
               mem_wr_en, reg_wr_en, illegal_instr, instr_done}), e.en);
         if (e.alu >= 0) check("alu_control", int'(alu_control), e.alu);
         if (e.rs >= 0) check("result_src", int'(result_src), e.rs);
         if (e.sel >= 0)
            check("alu_src", int'({alu_src_a, alu_src_b}), e.sel);
         if (e.imm >= 0) check("imm_src", int'(imm_src), e.imm);
      end
   end

   task automatic ins(input logic [6:0] op, input logic [2:0] f3,
                      input logic f7);
      n_op = op;
      n_f3 = f3;
      n_f7 = f7;
   endtask

   task automatic cyc(input int mr, input int z, input int st,
                      input int en, input int alu, input int rs,
                      input int sel, input int imm);
      exp_t e;
      @(posedge clk);
      #1;
      rst       = n_rst;
      opcode    = n_op;
      funct3    = n_f3;
      funct7_5  = n_f7;
      mem_ready = mr[0];
      zero      = z[0];
      e = '{st, en, alu, rs, sel, imm};
      exp_q.push_back(e);
   endtask

   task automatic fetch();
      cyc(1, 0, 0, 'b1110000, 0, 2, 'b0010, -1);
   endtask

   task automatic decode(input int imm);
      cyc(1, 0, 1, 0, 0, -1, 'b0101, imm);
   endtask

   task automatic alu_wb();
      cyc(1, 0, 8, 'b0000101, -1, 0, -1, -1);
   endtask

   initial begin
      // reset held three cycles with an ADD on the IR fields
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, -1, -1, -1, -1);
      n_rst = 1'b0;
      // ADD
      fetch();
      decode(-1);
      cyc(1, 0, 6, 0, 0, -1, 'b1000, -1);
      alu_wb();
      // SUB
      ins(7'b0110011, 3'b000, 1'b1);
      fetch();
      decode(-1);
      cyc(1, 0, 6, 0, 1, -1, 'b1000, -1);
      alu_wb();
      // ADDI with bit30 set stays ADD
      ins(7'b0010011, 3'b000, 1'b1);
      fetch();
      decode(0);
      cyc(1, 0, 7, 0, 0, -1, 'b1001, -1);
      alu_wb();
      // SRAI
      ins(7'b0010011, 3'b101, 1'b1);
      fetch();
      decode(0);
      cyc(1, 0, 7, 0, 7, -1, 'b1001, -1);
      alu_wb();
      // LW with two wait cycles in FETCH and MEM_RD
      ins(7'b0000011, 3'b010, 1'b0);
      cyc(0, 0, 0, 'b0010000, -1, -1, -1, -1);
      cyc(0, 0, 0, 'b0010000, -1, -1, -1, -1);
      fetch();
      decode(0);
      cyc(1, 0, 2, 0, 0, -1, 'b1001, -1);
      cyc(0, 0, 3, 'b0010000, -1, -1, -1, -1);
      cyc(0, 0, 3, 'b0010000, -1, -1, -1, -1);
      cyc(1, 0, 3, 'b0010000, -1, -1, -1, -1);
      cyc(1, 0, 4, 'b0000101, -1, 1, -1, -1);
      // SW
      ins(7'b0100011, 3'b010, 1'b0);
      fetch();
      decode(1);
      cyc(1, 0, 2, 0, 0, -1, 'b1001, -1);
      cyc(1, 0, 5, 'b0001001, -1, -1, -1, -1);
      // BNE not equal: taken
      ins(7'b1100011, 3'b001, 1'b0);
      fetch();
      decode(2);
      cyc(1, 0, 9, 'b1000001, 1, 0, 'b1000, -1);
      // BNE equal: not taken
      fetch();
      decode(2);
      cyc(1, 1, 9, 'b0000001, 1, 0, -1, -1);
      // BGE zero=1: taken
      ins(7'b1100011, 3'b101, 1'b0);
      fetch();
      decode(2);
      cyc(1, 1, 9, 'b1000001, 8, 0, -1, -1);
      // BLTU zero=1: not taken
      ins(7'b1100011, 3'b110, 1'b0);
      fetch();
      decode(2);
      cyc(1, 1, 9, 'b0000001, 9, 0, -1, -1);
      // illegal opcode
      ins(7'b1111111, 3'b000, 1'b0);
      fetch();
      cyc(1, 0, 1, 'b0000011, -1, -1, -1, -1);
      // JAL
      ins(7'b1101111, 3'b000, 1'b0);
      fetch();
      decode(4);
      cyc(1, 0, 10, 'b1000000, 0, 0, 'b0110, -1);
      alu_wb();
      // JALR
      ins(7'b1100111, 3'b000, 1'b0);
      fetch();
      decode(0);
      cyc(1, 0, 11, 0, 0, -1, 'b1001, -1);
      cyc(1, 0, 12, 'b1000000, 0, 0, 'b0110, -1);
      alu_wb();
      // LUI
      ins(7'b0110111, 3'b000, 1'b0);
      fetch();
      decode(3);
      cyc(1, 0, 13, 'b0000101, -1, 3, -1, -1);
      // AUIPC
      ins(7'b0010111, 3'b000, 1'b0);
      fetch();
      decode(3);
      alu_wb();
      // SW stalled in MEM_WR, then reset mid-instruction
      ins(7'b0100011, 3'b010, 1'b0);
      fetch();
      decode(1);
      cyc(1, 0, 2, 0, 0, -1, 'b1001, -1);
      cyc(0, 0, 5, 'b0001000, -1, -1, -1, -1);
      n_rst = 1'b1;
      cyc(0, 0, 5, 0, -1, -1, -1, -1);
      n_rst = 1'b0;
      fetch();
      decode(1);
      cyc(1, 0, 2, 0, 0, -1, 'b1001, -1);
      cyc(1, 0, 5, 'b0001001, -1, -1, -1, -1);

      @(negedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
